decode_register_bank: RTL and testbench

Parametrised successor of the register file inside the decode stage. It provides a configurable-width, configurable-depth register bank with N registered read ports and one write port, fed from writeback. It adds write-to-read bypass and an optional hard-wired zero register. It also has a sequenced dump port that streams every register to the debug unit through a valid/ready handshake. It sits in the decode stage, between writeback and the ID/EX outputs.

---
 rtl/decode_register_bank_pkg.sv | 14 +
 rtl/decode_register_bank_dump_ctrl.sv | 64 ++++++
 rtl/decode_register_bank.sv | 92 +++++++++
 tb/tb_decode_register_bank.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/decode_register_bank_pkg.sv
// Shared definitions for the decode-stage register bank: dump FSM encodings
// and the default geometry also used by instruction_decode.
package decode_register_bank_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        DUMP_IDLE   = 2'd0,
        DUMP_STREAM = 2'd1,
        DUMP_DONE   = 2'd2
    } dump_state_t;

endpackage

// File: rtl/decode_register_bank_dump_ctrl.sv
// Dump sequencer: walks every register index once through a valid/ready
// handshake, then pulses done for a single cycle.
module decode_register_bank_dump_ctrl
    import decode_register_bank_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_dump_start,
    input  logic                  i_dump_ready,
    output logic                  o_dump_valid,
    output logic [ADDR_WIDTH-1:0] o_dump_index,
    output logic                  o_dump_busy,
    output logic                  o_dump_done
);

    dump_state_t state;

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state        <= DUMP_IDLE;
            o_dump_index <= '0;
            o_dump_valid <= 1'b0;
            o_dump_busy  <= 1'b0;
            o_dump_done  <= 1'b0;
        end else begin
            case (state)
                DUMP_IDLE: begin
                    o_dump_done <= 1'b0;
                    if (i_dump_start) begin
                        state        <= DUMP_STREAM;
                        o_dump_index <= '0;
                        o_dump_valid <= 1'b1;
                        o_dump_busy  <= 1'b1;
                    end
                end
                DUMP_STREAM: begin
                    if (i_dump_ready) begin
                        if (o_dump_index == '1) begin
                            state        <= DUMP_DONE;
                            o_dump_valid <= 1'b0;
                            o_dump_done  <= 1'b1;
                        end else begin
                            o_dump_index <= o_dump_index + 1'b1;
                        end
                    end
                end
                DUMP_DONE: begin
                    state       <= DUMP_IDLE;
                    o_dump_done <= 1'b0;
                    o_dump_busy <= 1'b0;
                end
                default: begin
                    state        <= DUMP_IDLE;
                    o_dump_valid <= 1'b0;
                    o_dump_busy  <= 1'b0;
                    o_dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/decode_register_bank.sv
// Decode-stage register bank: N registered read ports with optional write
// bypass, one writeback port, optional zero register and a debug dump stream.
module decode_register_bank
    import decode_register_bank_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int unsigned NUM_READ_PORTS = 2,
    parameter int unsigned ZERO_REG       = 1,
    parameter int unsigned BYPASS         = 1
) (
    input  logic                                 i_clk,
    input  logic                                 i_reset,
    input  logic                                 i_stall,
    input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] i_rd_addr,
    output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] o_rd_data,
    input  logic                                 i_wr_en,
    input  logic [ADDR_WIDTH-1:0]                i_wr_addr,
    input  logic [DATA_WIDTH-1:0]                i_wr_data,
    input  logic                                 i_dump_start,
    input  logic                                 i_dump_ready,
    output logic                                 o_dump_valid,
    output logic [ADDR_WIDTH-1:0]                o_dump_index,
    output logic [DATA_WIDTH-1:0]                o_dump_data,
    output logic                                 o_dump_busy,
    output logic                                 o_dump_done
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0]                regs [DEPTH];
    logic [NUM_READ_PORTS*DATA_WIDTH-1:0] rd_next;
    logic                                 wr_allowed;

    assign wr_allowed = i_wr_en && !(ZERO_REG != 0 && i_wr_addr == '0);

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_allowed) begin
            regs[i_wr_addr] <= i_wr_data;
        end
    end

    // A zeroed register 0 never matches the bypass since wr_allowed excludes it.
    always_comb begin
        logic [ADDR_WIDTH-1:0] addr_k;
        rd_next = '0;
        addr_k  = '0;
        for (int unsigned k = 0; k < NUM_READ_PORTS; k++) begin
            addr_k = i_rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            if (ZERO_REG != 0 && addr_k == '0) begin
                rd_next[k*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (BYPASS != 0 && wr_allowed && i_wr_addr == addr_k) begin
                rd_next[k*DATA_WIDTH +: DATA_WIDTH] = i_wr_data;
            end else begin
                rd_next[k*DATA_WIDTH +: DATA_WIDTH] = regs[addr_k];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            o_rd_data <= '0;
        end else if (!i_stall) begin
            o_rd_data <= rd_next;
        end
    end

    decode_register_bank_dump_ctrl #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_dump_ctrl (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_dump_start (i_dump_start),
        .i_dump_ready (i_dump_ready),
        .o_dump_valid (o_dump_valid),
        .o_dump_index (o_dump_index),
        .o_dump_busy  (o_dump_busy),
        .o_dump_done  (o_dump_done)
    );

    always_comb begin
        o_dump_data = regs[o_dump_index];
        if (ZERO_REG != 0 && o_dump_index == '0) begin
            o_dump_data = '0;
        end
    end

endmodule

// File: tb/tb_decode_register_bank.sv
// Directed bench for decode_register_bank with default parameters
// (32x32, two read ports, zero register and bypass enabled).
module tb_decode_register_bank;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned NP = 2;

    logic              clk;
    logic              reset;
    logic              stall;
    logic [NP*AW-1:0]  rd_addr;
    logic [NP*DW-1:0]  rd_data;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [DW-1:0]     wr_data;
    logic              dump_start;
    logic              dump_ready;
    logic              dump_valid;
    logic [AW-1:0]     dump_index;
    logic [DW-1:0]     dump_data;
    logic              dump_busy;
    logic              dump_done;

    int n_pass;
    int n_total;

    decode_register_bank #(
        .DATA_WIDTH     (DW),
        .ADDR_WIDTH     (AW),
        .NUM_READ_PORTS (NP),
        .ZERO_REG       (1),
        .BYPASS         (1)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_stall      (stall),
        .i_rd_addr    (rd_addr),
        .o_rd_data    (rd_data),
        .i_wr_en      (wr_en),
        .i_wr_addr    (wr_addr),
        .i_wr_data    (wr_data),
        .i_dump_start (dump_start),
        .i_dump_ready (dump_ready),
        .o_dump_valid (dump_valid),
        .o_dump_index (dump_index),
        .o_dump_data  (dump_data),
        .o_dump_busy  (dump_busy),
        .o_dump_done  (dump_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic          wr_en;
        logic [AW-1:0] wr_addr;
        logic [DW-1:0] wr_data;
        logic          stall;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] e0;
        logic [DW-1:0] e1;
    } vec_t;

    vec_t vecs [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] port(input int unsigned k);
        return rd_data[k*DW +: DW];
    endfunction

    task automatic idle_inputs();
        wr_en = 1'b0; wr_addr = '0; wr_data = '0; stall = 1'b0;
        dump_start = 1'b0; dump_ready = 1'b0;
    endtask

    initial begin
        int unsigned exp_idx;
        int unsigned accepted;
        int unsigned cyc;
        logic        rdy;

        n_pass = 0;
        n_total = 0;
        rd_addr = '0;
        idle_inputs();

        // reset state
        reset = 1'b0;
        step();
        step();
        check("reset_rd0", port(0), 32'h0);
        check("reset_rd1", port(1), 32'h0);
        check("reset_valid", {31'b0, dump_valid}, 32'h0);
        check("reset_busy", {31'b0, dump_busy}, 32'h0);
        check("reset_done", {31'b0, dump_done}, 32'h0);
        check("reset_index", {27'b0, dump_index}, 32'h0);

        // reset clears a written register
        reset = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234;
        step();
        wr_en = 1'b0;
        rd_addr = {5'd0, 5'd5};
        step();
        check("pre_reset_rd5", port(0), 32'h1234);
        reset = 1'b0;
        step();
        check("in_reset_rd", port(0), 32'h0);
        reset = 1'b1;
        step();
        check("post_reset_rd5", port(0), 32'h0);
        check("post_reset_busy", {31'b0, dump_busy}, 32'h0);
        check("post_reset_done", {31'b0, dump_done}, 32'h0);

        //            wr    waddr  wdata          stall a0     a1     e0             e1
        vecs[0]  = '{1'b1, 5'd5,  32'h5,         1'b0, 5'd5,  5'd0,  32'h5,         32'h0};
        vecs[1]  = '{1'b1, 5'd5,  32'h6,         1'b0, 5'd5,  5'd5,  32'h6,         32'h6};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd5,  5'd5,  32'h6,         32'h6};
        vecs[3]  = '{1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0, 5'd0,  5'd0,  32'h0,         32'h0};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd0,  5'd5,  32'h0,         32'h6};
        vecs[5]  = '{1'b1, 5'd7,  32'h7,         1'b0, 5'd7,  5'd3,  32'h7,         32'h0};
        vecs[6]  = '{1'b1, 5'd3,  32'h33,        1'b1, 5'd3,  5'd7,  32'h7,         32'h0};
        vecs[7]  = '{1'b1, 5'd7,  32'h77,        1'b1, 5'd7,  5'd7,  32'h7,         32'h0};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,         1'b0, 5'd3,  5'd7,  32'h33,        32'h77};
        vecs[9]  = '{1'b1, 5'd31, 32'hDEAD_BEEF, 1'b0, 5'd31, 5'd30, 32'hDEAD_BEEF, 32'h0};
        vecs[10] = '{1'b1, 5'd30, 32'hA5,        1'b0, 5'd31, 5'd30, 32'hDEAD_BEEF, 32'hA5};
        vecs[11] = '{1'b0, 5'd31, 32'h1,         1'b0, 5'd31, 5'd31, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

        for (int i = 0; i < 12; i++) begin
            wr_en   = vecs[i].wr_en;
            wr_addr = vecs[i].wr_addr;
            wr_data = vecs[i].wr_data;
            stall   = vecs[i].stall;
            rd_addr = {vecs[i].a1, vecs[i].a0};
            step();
            check($sformatf("vec%0d_rd0", i), port(0), vecs[i].e0);
            check($sformatf("vec%0d_rd1", i), port(1), vecs[i].e1);
        end
        idle_inputs();

        // fill regs 1..31 with i*3; reg 0 stays zero
        for (int i = 1; i < 32; i++) begin
            wr_en = 1'b1; wr_addr = AW'(i); wr_data = DW'(i * 3);
            step();
        end
        wr_en = 1'b0;

        // dump with alternating back-pressure
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        exp_idx = 0;
        accepted = 0;
        cyc = 0;
        while (accepted < 32 && cyc < 200) begin
            check("dump_valid", {31'b0, dump_valid}, 32'h1);
            check("dump_busy", {31'b0, dump_busy}, 32'h1);
            check("dump_no_early_done", {31'b0, dump_done}, 32'h0);
            check("dump_index", {27'b0, dump_index}, exp_idx);
            check("dump_data", dump_data, exp_idx * 3);
            rdy = (cyc % 2 == 0);
            dump_ready = rdy;
            step();
            if (rdy) begin
                accepted++;
                exp_idx++;
            end
            cyc++;
        end
        dump_ready = 1'b0;
        check("dump_word_count", accepted, 32);
        check("done_pulse", {31'b0, dump_done}, 32'h1);
        check("done_busy", {31'b0, dump_busy}, 32'h1);
        check("done_valid", {31'b0, dump_valid}, 32'h0);
        step();
        check("after_done_pulse", {31'b0, dump_done}, 32'h0);
        check("after_done_busy", {31'b0, dump_busy}, 32'h0);
        step();
        check("idle_done", {31'b0, dump_done}, 32'h0);

        // reset mid-dump
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        dump_ready = 1'b1;
        cyc = 0;
        while (dump_index != 5'd10 && cyc < 100) begin
            step();
            cyc++;
        end
        check("reach_index10", {27'b0, dump_index}, 32'd10);
        dump_ready = 1'b0;
        reset = 1'b0;
        step();
        reset = 1'b1;
        check("abort_valid", {31'b0, dump_valid}, 32'h0);
        check("abort_busy", {31'b0, dump_busy}, 32'h0);
        check("abort_index", {27'b0, dump_index}, 32'h0);
        check("abort_done", {31'b0, dump_done}, 32'h0);
        step();
        check("abort_no_done", {31'b0, dump_done}, 32'h0);
        check("abort_idle_busy", {31'b0, dump_busy}, 32'h0);
        dump_start = 1'b1;
        step();
        dump_start = 1'b0;
        check("restart_valid", {31'b0, dump_valid}, 32'h1);
        check("restart_index", {27'b0, dump_index}, 32'h0);
        check("restart_data", dump_data, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
